start_pulse_gen: RTL and testbench

Drives a single-bit `start` strobe that is high for a programmed number of clock cycles and then low for a guaranteed minimum gap. The strobe always has the form "rising edge, high for N cycles, then low." This block is the producer side of the start-strobe protocol. Consumers and the start-width assertion checkers in the bench sample `start` on `posedge clk`. The block sits between a control/sequencer request port and any logic that consumes a start strobe.

---
 rtl/start_pulse_gen_pkg.sv | 18 +
 rtl/start_pulse_gen_if.sv | 36 +++
 rtl/start_pulse_gen.sv | 121 ++++++++++++
 tb/tb_start_pulse_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/start_pulse_gen_pkg.sv
// rtl/start_pulse_gen_pkg.sv - shared types and defaults for the start strobe generator
//
// Purpose: state encoding and default width shared by the interface and the
//          generator.
// Contents:
//   PG_CNT_W_DEFAULT  default width of request/report length fields
//   pg_state_t        generator state (IDLE, ACTIVE, GAP)
package start_pulse_pkg;

  localparam int PG_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    PG_IDLE   = 2'd0,
    PG_ACTIVE = 2'd1,
    PG_GAP    = 2'd2
  } pg_state_t;

endpackage

// File: rtl/start_pulse_gen_if.sv
// rtl/start_pulse_gen_if.sv - request handshake and completion report bundle
//
// Purpose: groups the sequencer-facing request handshake and the completion
//          report of start_pulse_gen.
// Signals:
//   req_valid  master->slave  pulse request
//   req_len    master->slave  requested high time in cycles
//   req_ready  slave->master  generator can accept a request
//   done       slave->master  one-cycle completion pulse
//   done_len   slave->master  cycles start was high, held between pulses
//   aborted    slave->master  qualifies done: pulse was cut short
// Modports: master (sequencer side), slave (generator side).
interface start_pulse_gen_if
  import start_pulse_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W_DEFAULT
);

  logic             req_valid;
  logic [CNT_W-1:0] req_len;
  logic             req_ready;
  logic             done;
  logic [CNT_W-1:0] done_len;
  logic             aborted;

  modport master (
    output req_valid, req_len,
    input  req_ready, done, done_len, aborted
  );

  modport slave (
    input  req_valid, req_len,
    output req_ready, done, done_len, aborted
  );

endinterface

// File: rtl/start_pulse_gen.sv
// rtl/start_pulse_gen.sv - programmable-width start strobe with guaranteed low gap
//
// Purpose: produces a registered start strobe that is high for a requested
//          number of cycles, then low for at least GAP_CYCLES cycles before
//          another request can be taken. An active pulse can be cut short
//          by abort; each finished pulse reports its real high time.
// Parameters:
//   CNT_W       width of req_len / done_len (max pulse 2^CNT_W-1)
//   GAP_CYCLES  minimum low cycles after each pulse, >= 1
// Ports:
//   clk       sole clock, posedge
//   rst_n     asynchronous active-low reset
//   req       request handshake + completion report (slave side)
//   abort     ends an active pulse early; ignored outside ACTIVE
//   start     generated strobe
//   busy      high in ACTIVE and GAP
//   err_zero  one-cycle flag for a rejected zero-length request
module start_pulse_gen
  import start_pulse_pkg::*;
#(
  parameter int CNT_W      = PG_CNT_W_DEFAULT,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  start_pulse_gen_if.slave    req,
  input  logic                abort,
  output logic                start,
  output logic                busy,
  output logic                err_zero
);

  localparam logic [1:0] S_IDLE   = PG_IDLE;
  localparam logic [1:0] S_ACTIVE = PG_ACTIVE;
  localparam logic [1:0] S_GAP    = PG_GAP;

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_q        <= '0;
      cnt          <= '0;
      gcnt         <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      err_zero     <= 1'b0;
      req.req_ready <= 1'b1;
      req.done     <= 1'b0;
      req.done_len <= '0;
      req.aborted  <= 1'b0;
    end else begin
      req.done <= 1'b0;
      err_zero <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req.req_valid && req.req_ready) begin
            if (req.req_len == '0) begin
              err_zero <= 1'b1;
            end else begin
              // start rises on this edge, so the counter already holds the
              // first high cycle; it always equals high cycles seen so far.
              len_q         <= req.req_len;
              cnt           <= CNT_W'(1);
              start         <= 1'b1;
              busy          <= 1'b1;
              req.req_ready <= 1'b0;
              state         <= S_ACTIVE;
            end
          end
        end

        S_ACTIVE: begin
          // Reaching the length wins over a simultaneous abort.
          if (cnt == len_q) begin
            start        <= 1'b0;
            req.done     <= 1'b1;
            req.done_len <= len_q;
            req.aborted  <= 1'b0;
            gcnt         <= GW'(1);
            state        <= S_GAP;
          end else if (abort) begin
            start        <= 1'b0;
            req.done     <= 1'b1;
            req.done_len <= cnt;
            req.aborted  <= 1'b1;
            gcnt         <= GW'(1);
            state        <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            busy          <= 1'b0;
            req.req_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end

        default: begin
          start         <= 1'b0;
          busy          <= 1'b0;
          req.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_pulse_gen.sv
// tb/tb_start_pulse_gen.sv - directed self-checking bench for start_pulse_gen
module tb_start_pulse_gen;

  logic clk;
  logic rst_n;
  logic abort;
  logic start1, busy1, err1;
  logic start3, busy3, err3;

  int errors = 0;
  int checks = 0;

  start_pulse_gen_if #(.CNT_W(8)) if1 ();
  start_pulse_gen_if #(.CNT_W(8)) if3 ();

  start_pulse_gen #(.CNT_W(8), .GAP_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (if1),
    .abort    (abort),
    .start    (start1),
    .busy     (busy1),
    .err_zero (err1)
  );

  start_pulse_gen #(.CNT_W(8), .GAP_CYCLES(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (if3),
    .abort    (abort),
    .start    (start3),
    .busy     (busy3),
    .err_zero (err3)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // start-width monitor for dut1: counts sampled-high cycles per pulse
  int run = 0;
  int last_width = 0;
  int done_seen = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 0;
    end else if (start1) begin
      run <= run + 1;
    end else if (run != 0) begin
      last_width <= run;
      run <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && if1.done) done_seen <= done_seen + 1;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    abort = 1'b0;
    if1.req_valid = 1'b0; if1.req_len = 8'd0;
    if3.req_valid = 1'b0; if3.req_len = 8'd0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", start1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", if1.req_ready); end
    checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", if1.done); end
    checks++; if (if1.aborted !== 1'b0) begin errors++; $display("FAIL rst_aborted got=%b exp=0", if1.aborted); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err_zero got=%b exp=0", err1); end
    checks++; if (if1.done_len !== 8'd0) begin errors++; $display("FAIL rst_done_len got=%0d exp=0", if1.done_len); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int k;
    if1.req_valid = 1'b1; if1.req_len = 8'd5;
    @(negedge clk);
    if1.req_valid = 1'b0;
    checks++; if (start1 !== 1'b1) begin errors++; $display("FAIL basic_start_rise got=%b exp=1", start1); end
    checks++; if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low got=%b exp=0", if1.req_ready); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy1); end
    k = 0;
    while (if1.done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++; if (k != 5) begin errors++; $display("FAIL basic_done_latency got=%0d exp=5", k); end
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL basic_start_fall got=%b exp=0", start1); end
    checks++; if (if1.done_len !== 8'd5) begin errors++; $display("FAIL basic_done_len got=%0d exp=5", if1.done_len); end
    checks++; if (if1.aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted got=%b exp=0", if1.aborted); end
    @(negedge clk);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", if1.req_ready); end
    checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got=%b exp=0", if1.done); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_clear got=%b exp=0", busy1); end
    checks++; if (last_width != 5) begin errors++; $display("FAIL basic_width got=%0d exp=5", last_width); end
  endtask

  task automatic test_zero();
    if1.req_valid = 1'b1; if1.req_len = 8'd0;
    @(negedge clk);
    if1.req_valid = 1'b0;
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL zero_err got=%b exp=1", err1); end
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL zero_start got=%b exp=0", start1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy1); end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", if1.req_ready); end
    @(negedge clk);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL zero_err_one_cycle got=%b exp=0", err1); end
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL zero_start_later got=%b exp=0", start1); end
  endtask

  task automatic test_abort();
    if1.req_valid = 1'b1; if1.req_len = 8'd8;
    @(negedge clk);
    if1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL abort_start_fall got=%b exp=0", start1); end
    checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL abort_done got=%b exp=1", if1.done); end
    checks++; if (if1.done_len !== 8'd3) begin errors++; $display("FAIL abort_done_len got=%0d exp=3", if1.done_len); end
    checks++; if (if1.aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got=%b exp=1", if1.aborted); end
    @(negedge clk);
    checks++; if (last_width != 3) begin errors++; $display("FAIL abort_width got=%0d exp=3", last_width); end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back got=%b exp=1", if1.req_ready); end
  endtask

  task automatic test_abort_last();
    if1.req_valid = 1'b1; if1.req_len = 8'd4;
    @(negedge clk);
    if1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL last_done got=%b exp=1", if1.done); end
    checks++; if (if1.done_len !== 8'd4) begin errors++; $display("FAIL last_done_len got=%0d exp=4", if1.done_len); end
    checks++; if (if1.aborted !== 1'b0) begin errors++; $display("FAIL last_aborted got=%b exp=0", if1.aborted); end
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL last_start_fall got=%b exp=0", start1); end
    @(negedge clk);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL gap_abort_ready got=%b exp=1", if1.req_ready); end
    checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL gap_abort_done got=%b exp=0", if1.done); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL gap_abort_busy got=%b exp=0", busy1); end
    checks++; if (last_width != 4) begin errors++; $display("FAIL last_width got=%0d exp=4", last_width); end
    @(negedge clk);
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL idle_abort_start got=%b exp=0", start1); end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_s;
    if3.req_len = 8'd2;
    if3.req_valid = 1'b1;
    // GAP_CYCLES=3: 2 high samples, then GAP+1=4 low samples, period 6
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_s = ((i % 6) < 2) ? 1'b1 : 1'b0;
      checks++;
      if (start3 !== exp_s) begin
        errors++;
        $display("FAIL b2b_start[%0d] got=%b exp=%b", i, start3, exp_s);
      end
    end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL b2b_err_zero got=%b exp=0", err3); end
    if3.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got=%b exp=0", busy3); end
  endtask

  task automatic test_reset_mid();
    int k;
    int done_before;
    done_before = done_seen;
    if1.req_valid = 1'b1; if1.req_len = 8'd255;
    @(negedge clk);
    if1.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (start1 !== 1'b1) begin errors++; $display("FAIL mid_start_high got=%b exp=1", start1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL mid_async_start got=%b exp=0", start1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_async_busy got=%b exp=0", busy1); end
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%b exp=1", if1.req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done_seen != done_before) begin errors++; $display("FAIL mid_no_done got=%0d exp=%0d", done_seen, done_before); end
    if1.req_valid = 1'b1; if1.req_len = 8'd1;
    @(negedge clk);
    if1.req_valid = 1'b0;
    checks++; if (start1 !== 1'b1) begin errors++; $display("FAIL post_start got=%b exp=1", start1); end
    k = 0;
    while (if1.done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++; if (k != 1) begin errors++; $display("FAIL post_done_latency got=%0d exp=1", k); end
    checks++; if (if1.done_len !== 8'd1) begin errors++; $display("FAIL post_done_len got=%0d exp=1", if1.done_len); end
    checks++; if (if1.aborted !== 1'b0) begin errors++; $display("FAIL post_aborted got=%b exp=0", if1.aborted); end
    @(negedge clk);
    checks++; if (last_width != 1) begin errors++; $display("FAIL post_width got=%0d exp=1", last_width); end
    checks++; if (done_seen != done_before + 1) begin errors++; $display("FAIL post_done_count got=%0d exp=%0d", done_seen, done_before + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_abort_last();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
